// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage IF-ID-EX-MEM-WB pipeline.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mis_any,
   input  logic             mis_nt,
   input  logic             pred_taken,
   input  logic             ld_use,
   input  logic             mem_busy,
   input  logic             halt_ex,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             if_id_we,
   output logic             id_ex_we,
   output logic             ex_mem_we,
   output logic             if_id_flush,
   output logic             id_ex_flush,
`ifdef PIPE_PERF_CNT_EN
   output logic [CNT_W-1:0] mis_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt,
`endif
   output logic             halted
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam logic [1:0] BUB_INIT = 2'(FLUSH_CYCLES - 1);

   state_t     state_r, state_nxt_s;
   logic [1:0] bub_r, bub_nxt_s;

   generate
      if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3 || CNT_W < 1) begin : g_param_err
         $error("pipeline_hazard_ctrl: FLUSH_CYCLES must be 1..3 and CNT_W >= 1");
      end
   endgenerate

   // State and bubble counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_RUN;
         bub_r   <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         bub_r   <= bub_nxt_s;
      end
   end

   // Next-state and control outputs; reset forces a safe frozen/flushed pipeline
   always_comb begin
      state_nxt_s = state_r;
      bub_nxt_s   = bub_r;
      pc_we       = 1'b0;
      pc_sel      = 2'b00;
      if_id_we    = 1'b0;
      id_ex_we    = 1'b0;
      ex_mem_we   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      halted      = 1'b0;
      if (!rst) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (mem_busy) begin
                  pc_we = 1'b0;
               end else if (mis_any) begin
                  pc_we       = 1'b1;
                  if_id_we    = 1'b1;
                  id_ex_we    = 1'b1;
                  ex_mem_we   = 1'b1;
                  pc_sel      = mis_nt ? 2'b11 : 2'b10;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     state_nxt_s = ST_FLUSH;
                     bub_nxt_s   = BUB_INIT;
                  end else begin
                     state_nxt_s = ST_RUN;
                  end
               end else if (halt_ex) begin
                  // Younger instructions are squashed; EX and beyond keep draining
                  if_id_we    = 1'b1;
                  id_ex_we    = 1'b1;
                  ex_mem_we   = 1'b1;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  state_nxt_s = ST_HALT;
               end else if (ld_use) begin
                  id_ex_we    = 1'b1;
                  ex_mem_we   = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (pred_taken) begin
                  pc_we     = 1'b1;
                  if_id_we  = 1'b1;
                  id_ex_we  = 1'b1;
                  ex_mem_we = 1'b1;
                  pc_sel    = 2'b01;
               end else begin
                  pc_we     = 1'b1;
                  if_id_we  = 1'b1;
                  id_ex_we  = 1'b1;
                  ex_mem_we = 1'b1;
               end
            end
            ST_FLUSH: begin
               if (mem_busy) begin
                  pc_we = 1'b0;
               end else begin
                  pc_we       = 1'b1;
                  if_id_we    = 1'b1;
                  id_ex_we    = 1'b1;
                  ex_mem_we   = 1'b1;
                  id_ex_flush = 1'b1;
                  if (bub_r <= 2'd1) begin
                     state_nxt_s = ST_RUN;
                     bub_nxt_s   = 2'd0;
                  end else begin
                     bub_nxt_s = bub_r - 2'd1;
                  end
               end
            end
            ST_HALT: begin
               ex_mem_we = 1'b1;
               halted    = 1'b1;
            end
            default: begin
               state_nxt_s = ST_RUN;
               bub_nxt_s   = 2'd0;
            end
         endcase
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic mis_inc_s, stall_inc_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic en);
      if (en && (val != {CNT_W{1'b1}})) begin
         return val + CNT_W'(1);
      end else begin
         return val;
      end
   endfunction

   assign mis_inc_s   = (state_r == ST_RUN) && !mem_busy && mis_any;
   assign stall_inc_s = (state_r != ST_HALT) && mem_busy;

   // Saturating performance counters, cleared only by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mis_cnt    <= {CNT_W{1'b0}};
         stall_cnt  <= {CNT_W{1'b0}};
         bubble_cnt <= {CNT_W{1'b0}};
      end else begin
         mis_cnt    <= sat_inc(mis_cnt, mis_inc_s);
         stall_cnt  <= sat_inc(stall_cnt, stall_inc_s);
         bubble_cnt <= sat_inc(bubble_cnt, id_ex_flush);
      end
   end
`endif

endmodule
